// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with in-order commit; optional ROB_CDB_BYPASS_EN forwards CDB to queries
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    input  logic [AW-1:0]     alloc_addr,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_value,
    output logic [DATA_W-1:0] q2_value,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [3:0]        commit_func,
    output logic [3:0]        commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic              reg_we,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic              flush,
    output logic [3:0]        flush_pc,
    output logic [TAG_W:0]    count
);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  rdy;
    logic [3:0]        func_q  [DEPTH];
    logic [3:0]        rd_q    [DEPTH];
    logic [AW-1:0]     addr_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;

    logic       alloc_fire;
    logic       cdb_write;
    logic       commit_fire;
    logic       flush_fire;
    logic [3:0] head_func;

    assign alloc_ready = (count < (TAG_W + 1)'(DEPTH));
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    // a broadcast only lands on an entry that is still waiting for its result
    assign cdb_write   = cdb_valid && busy[cdb_tag] && !rdy[cdb_tag];
    assign commit_fire = busy[head] && rdy[head];
    assign head_func   = func_q[head];
    assign flush_fire  = commit_fire && ((head_func == 4'd6) || (head_func == 4'd7))
                         && value_q[head][0];

    // entry state, pointers and occupancy; a mispredict commit wipes everything
    always_ff @(posedge clk1) begin
        if (!rst_n || flush_fire) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            rdy   <= '0;
        end else begin
            if (alloc_fire) begin
                busy[tail]   <= 1'b1;
                rdy[tail]    <= 1'b0;
                func_q[tail] <= alloc_func;
                rd_q[tail]   <= alloc_rd;
                addr_q[tail] <= alloc_addr;
                tail         <= tail + TAG_W'(1);
            end
            if (cdb_write) begin
                rdy[cdb_tag]     <= 1'b1;
                value_q[cdb_tag] <= cdb_value;
            end
            if (commit_fire) begin
                busy[head] <= 1'b0;
                rdy[head]  <= 1'b0;
                head       <= head + TAG_W'(1);
            end
            count <= count + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(commit_fire);
        end
    end

    // one-cycle retire outputs decoded from the head entry's opcode
    always_ff @(posedge clk1) begin
        if (!rst_n || !commit_fire) begin
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_func  <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            reg_we       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else begin
            commit_valid <= 1'b1;
            commit_tag   <= head;
            commit_func  <= head_func;
            commit_rd    <= rd_q[head];
            commit_value <= value_q[head];
            reg_we       <= (head_func <= 4'd4);
            mem_we       <= (head_func == 4'd5);
            mem_addr     <= (head_func == 4'd5) ? addr_q[head] : '0;
            flush        <= flush_fire;
            flush_pc     <= flush_fire ? addr_q[head][3:0] : 4'd0;
        end
    end

    // operand lookup for issue, optionally forwarding the live broadcast
    always_comb begin
        q1_ready = busy[q1_tag] && rdy[q1_tag];
        q1_value = value_q[q1_tag];
        q2_ready = busy[q2_tag] && rdy[q2_tag];
        q2_value = value_q[q2_tag];
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_tag == q1_tag) && busy[q1_tag]) begin
            q1_ready = 1'b1;
            q1_value = cdb_value;
        end
        if (cdb_valid && (cdb_tag == q2_tag) && busy[q2_tag]) begin
            q2_ready = 1'b1;
            q2_value = cdb_value;
        end
`endif
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - scoreboard bench for rob_commit against a queue-based program-order model
module tb_rob_commit;

    localparam int DEPTH = 8;

    logic        clk1 = 0;
    logic        rst_n = 0;
    logic        alloc_valid = 0;
    logic [3:0]  alloc_func = 0;
    logic [3:0]  alloc_rd = 0;
    logic [7:0]  alloc_addr = 0;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid = 0;
    logic [2:0]  cdb_tag = 0;
    logic [15:0] cdb_value = 0;
    logic [2:0]  q1_tag = 0;
    logic [2:0]  q2_tag = 0;
    logic        q1_ready, q2_ready;
    logic [15:0] q1_value, q2_value;
    logic        commit_valid;
    logic [2:0]  commit_tag;
    logic [3:0]  commit_func, commit_rd;
    logic [15:0] commit_value;
    logic        reg_we, mem_we, flush;
    logic [7:0]  mem_addr;
    logic [3:0]  flush_pc;
    logic [3:0]  count;

    rob_commit dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_addr(alloc_addr), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_func(commit_func),
        .commit_rd(commit_rd), .commit_value(commit_value), .reg_we(reg_we),
        .mem_we(mem_we), .mem_addr(mem_addr), .flush(flush), .flush_pc(flush_pc),
        .count(count)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int          tag;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic [7:0]  addr;
        bit          done;
        logic [15:0] val;
    } ent_t;

    typedef struct {
        int          edge_no;
        logic [2:0]  tag;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic [15:0] val;
        bit          reg_we;
        bit          mem_we;
        logic [7:0]  addr;
        bit          flush;
        logic [3:0]  fpc;
    } exp_t;

    ent_t rob[$];
    exp_t sb[$];
    int   next_tag = 0;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    bit   mon_en = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // program-order model: what happens at the upcoming edge given current inputs
    task automatic model_edge();
        bit   cf;
        bit   fl;
        exp_t e;
        if (!rst_n) begin
            rob.delete();
            next_tag = 0;
            return;
        end
        cf = (rob.size() > 0) && rob[0].done;
        fl = 0;
        if (cf) begin
            e.edge_no = cyc + 1;
            e.tag     = 3'(rob[0].tag);
            e.func    = rob[0].func;
            e.rd      = rob[0].rd;
            e.val     = rob[0].val;
            e.reg_we  = rob[0].func <= 4;
            e.mem_we  = rob[0].func == 5;
            e.addr    = rob[0].addr;
            fl        = (rob[0].func == 6 || rob[0].func == 7) && rob[0].val[0];
            e.flush   = fl;
            e.fpc     = rob[0].addr[3:0];
            sb.push_back(e);
        end
        if (fl) begin
            rob.delete();
            next_tag = 0;
            return;
        end
        if (cdb_valid)
            foreach (rob[i])
                if (rob[i].tag == int'(cdb_tag) && !rob[i].done) begin
                    rob[i].done = 1;
                    rob[i].val  = cdb_value;
                end
        if (alloc_valid && rob.size() < DEPTH) begin
            ent_t n;
            n.tag  = next_tag;
            n.func = alloc_func;
            n.rd   = alloc_rd;
            n.addr = alloc_addr;
            n.done = 0;
            n.val  = '0;
            rob.push_back(n);
            next_tag = (next_tag + 1) % DEPTH;
        end
        if (cf) void'(rob.pop_front());
    endtask

    task automatic chk_query(input string nm, input logic [2:0] qt, input logic r, input logic [15:0] v);
        bit          er = 0;
        logic [15:0] ev = '0;
        foreach (rob[i])
            if (rob[i].tag == int'(qt)) begin
                er = rob[i].done;
                ev = rob[i].val;
`ifdef ROB_CDB_BYPASS_EN
                if (cdb_valid && cdb_tag == qt) begin
                    er = 1;
                    ev = cdb_value;
                end
`endif
            end
        chk({nm, "_ready"}, 32'(r), 32'(er));
        if (er) chk({nm, "_value"}, 32'(v), 32'(ev));
    endtask

    task automatic step(input bit av, input logic [3:0] f, input logic [3:0] rd,
                        input logic [7:0] ad, input bit cv, input logic [2:0] ct,
                        input logic [15:0] cval, input logic [2:0] qa, input logic [2:0] qb);
        @(negedge clk1);
        #1;
        alloc_valid = av; alloc_func = f; alloc_rd = rd; alloc_addr = ad;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
        q1_tag = qa; q2_tag = qb;
        #1;
        if (rst_n) begin
            chk("count", 32'(count), 32'(rob.size()));
            chk("alloc_ready", 32'(alloc_ready), 32'(rob.size() < DEPTH));
            chk("alloc_tag", 32'(alloc_tag), 32'(next_tag));
            chk_query("q1", qa, q1_ready, q1_value);
            chk_query("q2", qb, q2_ready, q2_value);
        end
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 3'($urandom), 3'($urandom));
    endtask

    task automatic alloc(input logic [3:0] f, input logic [3:0] rd, input logic [7:0] ad);
        step(1, f, rd, ad, 0, 0, 0, 0, 0);
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] v, input logic [2:0] qa);
        step(0, 0, 0, 0, 1, t, v, qa, t);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (rob.size() > 0 || sb.size() > 0); i++) begin
            int k = -1;
            foreach (rob[j]) if (k < 0 && !rob[j].done) k = j;
            if (k >= 0) cdb(3'(rob[k].tag), 16'($urandom & 16'hFFFE), 0);
            else idle(1);
        end
        chk("drained", 32'(rob.size() + sb.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        #1;
        rst_n = 0; alloc_valid = 1; alloc_func = 4'd0; cdb_valid = 0;
        model_edge();
        @(negedge clk1);
        #1;
        model_edge();
        @(negedge clk1);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_tag", 32'(alloc_tag), 0);
        chk("rst_commit_valid", 32'(commit_valid), 0);
        chk("rst_outs", 32'({reg_we, mem_we, flush, flush_pc, mem_addr, commit_value}), 0);
        rst_n = 1; alloc_valid = 0;
    endtask

    // monitor: every cycle the retire outputs must match the next due scoreboard entry
    always @(negedge clk1) begin
        if (mon_en) begin
            bit   due;
            exp_t e;
            due = (sb.size() > 0) && (sb[0].edge_no == cyc);
            chk("commit_valid", 32'(commit_valid), 32'(due));
            if (due) begin
                e = sb.pop_front();
                chk("commit_tag", 32'(commit_tag), 32'(e.tag));
                chk("commit_func", 32'(commit_func), 32'(e.func));
                chk("commit_rd", 32'(commit_rd), 32'(e.rd));
                chk("commit_value", 32'(commit_value), 32'(e.val));
                chk("reg_we", 32'(reg_we), 32'(e.reg_we));
                chk("mem_we", 32'(mem_we), 32'(e.mem_we));
                chk("flush", 32'(flush), 32'(e.flush));
                if (e.mem_we) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.flush) chk("flush_pc", 32'(flush_pc), 32'(e.fpc));
            end else if (sb.size() > 0 && sb[0].edge_no < cyc) begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        mon_en = 1;

        // single add, result next cycle
        alloc(4'd0, 4'd3, 8'h00);
        cdb(3'd0, 16'h0012, 3'd0);
        idle(3);

        // out-of-order completion, in-order retire
        alloc(4'd0, 4'd1, 0); alloc(4'd1, 4'd2, 0); alloc(4'd2, 4'd4, 0);
        cdb(3'd2, 16'h0022, 3'd2); cdb(3'd1, 16'h0011, 3'd1); cdb(3'd0, 16'h0010, 3'd0);
        idle(5);

        // fill, overfill, then wrap
        for (int i = 0; i < 9; i++) alloc(4'd0, 4'(i), 0);
        chk("full_count", 32'(count), 8);
        chk("full_ready", 32'(alloc_ready), 0);
        cdb(3'(rob[0].tag), 16'h0100, 0);
        idle(2);
        alloc(4'd1, 4'd9, 0);
        drain();

        // store
        alloc(4'd5, 4'd0, 8'h40);
        cdb(3'(rob[0].tag), 16'hBEEF, 0);
        idle(3);
        drain();

        // mispredicted branch squashes younger work
        do_reset();
        alloc(4'd0, 4'd1, 0); alloc(4'd6, 4'd0, 8'h05); alloc(4'd0, 4'd2, 0); alloc(4'd1, 4'd3, 0);
        cdb(3'd2, 16'h0007, 3'd2);
        cdb(3'd0, 16'h0001, 3'd0);
        cdb(3'd1, 16'h0001, 3'd1);
        idle(4);
        chk("flush_count", 32'(count), 0);

        // randomized traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            int          idx[$];
            bit          cv;
            logic [2:0]  ct;
            if (n == 700) do_reset();
            foreach (rob[i]) if (!rob[i].done) idx.push_back(i);
            if (idx.size() > 0 && $urandom % 4 != 0) begin
                cv = 1;
                ct = 3'(rob[idx[$urandom % idx.size()]].tag);
            end else begin
                cv = 1'($urandom);
                ct = 3'($urandom);
            end
            step(1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), cv, ct,
                 16'($urandom), 3'($urandom), 3'($urandom));
        end
        drain();
        idle(2);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
